// File: rtl/pico_uart_tx_port_if.sv
// Port-bus signals between the KCPSM3 wrapper and the UART TX peripheral.
// The processor side drives address/data/strobes and receives rd_data.
interface pico_uart_tx_port_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] rd_data;

    modport master (
        output port_id, write_strobe, read_strobe, out_port,
        input  rd_data
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port,
        output rd_data
    );
endinterface

// File: rtl/pico_uart_tx_port.sv
// PicoBlaze port-bus UART transmitter: 8N1 frames fed from a circular FIFO,
// plus a registered status byte for firmware polling.
module pico_uart_tx_port #(
    parameter int unsigned CLK_DIV     = 868,
    parameter logic [7:0]  DATA_PORT   = 8'h01,
    parameter logic [7:0]  STATUS_PORT = 8'h02,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    pico_uart_tx_port_if.slave      bus,
    output logic                    tx,
    output logic                    busy,
    output logic                    fifo_full
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [2:0]           bit_idx, bit_idx_d;
    logic [7:0]           shift, shift_d;
    logic                 tx_d;

    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wptr, rptr;
    logic [FIFO_AW:0]     count;
    logic                 overflow;
    logic                 empty, full;
    logic                 wr_data, flush, status_rd;
    logic                 push, pop, ovf_evt, bit_tick;
    logic [7:0]           status;

    assign empty     = (count == '0);
    assign full      = (count == (FIFO_AW + 1)'(DEPTH));
    assign wr_data   = bus.write_strobe && (bus.port_id == DATA_PORT);
    assign flush     = bus.write_strobe && (bus.port_id == STATUS_PORT) && bus.out_port[7];
    assign status_rd = bus.read_strobe && (bus.port_id == STATUS_PORT);
    // Fullness is judged before the edge, so a same-cycle pop never rescues a push.
    assign push      = wr_data && !full;
    assign ovf_evt   = wr_data && full;
    assign bit_tick  = (cnt == CNT_W'(CLK_DIV - 1));
    assign status    = {4'b0000, overflow, (state != IDLE), full, empty};

    assign busy      = !empty || (state != IDLE);
    assign fifo_full = full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= bus.out_port;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            bus.rd_data <= '0;
        end else begin
            if (flush) begin
                rptr  <= wptr;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + FIFO_AW'(1);
                if (pop)  rptr <= rptr + FIFO_AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (FIFO_AW + 1)'(1);
                    2'b01:   count <= count - (FIFO_AW + 1)'(1);
                    default: count <= count;
                endcase
            end
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (flush || status_rd) begin
                overflow <= 1'b0;
            end
            bus.rd_data <= (bus.port_id == STATUS_PORT) ? status : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            tx      <= tx_d;
        end
    end

    // A flush in the same cycle suppresses the pop so the flushed bytes never start a frame.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !flush) begin
                    pop     = 1'b1;
                    shift_d = mem[rptr];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    shift_d   = shift >> 1;
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (!empty && !flush) begin
                        pop     = 1'b1;
                        shift_d = mem[rptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next-state view so each bit lasts exactly CLK_DIV cycles.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_pico_uart_tx_port.sv
// Directed bench for pico_uart_tx_port with CLK_DIV=4; cycle c counts edges
// after the first push of a scenario (edge k is c=0).
module tb_pico_uart_tx_port;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    logic clk = 1'b0;
    logic reset;
    logic tx, busy, fifo_full;

    int checks = 0;
    int errors = 0;
    logic [7:0] fb [0:31];

    pico_uart_tx_port_if bus ();

    pico_uart_tx_port #(
        .CLK_DIV    (DIV),
        .DATA_PORT  (8'h01),
        .STATUS_PORT(8'h02),
        .FIFO_AW    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tx       (tx),
        .busy     (busy),
        .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.port_id      = 8'h00;
        bus.write_strobe = 1'b0;
        bus.read_strobe  = 1'b0;
        bus.out_port     = 8'h00;
    endtask

    task automatic bus_write(input logic [7:0] port, input logic [7:0] data);
        bus.port_id      = port;
        bus.write_strobe = 1'b1;
        bus.read_strobe  = 1'b0;
        bus.out_port     = data;
    endtask

    // Expected serial line level after edge c for n back-to-back frames of fb[].
    function automatic logic exp_line(input int c, input int n);
        int f, pos, seg;
        logic [7:0] b;
        if (c < 1) return 1'b1;
        f = (c - 1) / FRAME;
        if (f >= n) return 1'b1;
        pos = (c - 1) % FRAME;
        seg = pos / DIV;
        b = fb[f];
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus_idle();
        tick();
        tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd: got %h expected 00", bus.rd_data); end
        reset = 1'b0;
        bus.port_id     = 8'h02;
        bus.read_strobe = 1'b1;
        tick();
        bus_idle();
        checks++; if (bus.rd_data !== 8'h01) begin errors++; $display("FAIL reset_status: got %h expected 01", bus.rd_data); end
    endtask

    task automatic test_single_frame();
        fb[0] = 8'h55;
        for (int c = 0; c <= 41; c++) begin
            if (c == 0) bus_write(8'h01, 8'h55); else bus_idle();
            tick();
            checks++;
            if (tx !== exp_line(c, 1)) begin errors++; $display("FAIL single_tx c=%0d: got %b expected %b", c, tx, exp_line(c, 1)); end
            checks++;
            if (busy !== (c < 41)) begin errors++; $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, c < 41); end
        end
    endtask

    task automatic test_back_to_back();
        fb[0] = 8'h00; fb[1] = 8'hFF; fb[2] = 8'hA5;
        for (int c = 0; c <= 121; c++) begin
            if (c < 3) bus_write(8'h01, fb[c]); else bus_idle();
            tick();
            checks++;
            if (tx !== exp_line(c, 3)) begin errors++; $display("FAIL b2b_tx c=%0d: got %b expected %b", c, tx, exp_line(c, 3)); end
            checks++;
            if (busy !== (c < 121)) begin errors++; $display("FAIL b2b_busy c=%0d: got %b expected %b", c, busy, c < 121); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) fb[i] = 8'(i);
        for (int c = 0; c <= 681; c++) begin
            if (c < 18) begin
                bus_write(8'h01, 8'(c));
            end else if (c == 18) begin
                bus_idle();
                bus.port_id = 8'h02;
            end else begin
                bus_idle();
            end
            tick();
            checks++;
            if (tx !== exp_line(c, 17)) begin errors++; $display("FAIL ovf_tx c=%0d: got %b expected %b", c, tx, exp_line(c, 17)); end
            checks++;
            if (busy !== (c < 681)) begin errors++; $display("FAIL ovf_busy c=%0d: got %b expected %b", c, busy, c < 681); end
            checks++;
            if (fifo_full !== (c >= 16 && c < 41)) begin
                errors++; $display("FAIL ovf_full c=%0d: got %b expected %b", c, fifo_full, c >= 16 && c < 41);
            end
            if (c == 18) begin
                checks++;
                if (bus.rd_data !== 8'h0E) begin errors++; $display("FAIL ovf_status: got %h expected 0e", bus.rd_data); end
            end
        end
    endtask

    task automatic test_status_flush();
        bus.port_id     = 8'h02;
        bus.read_strobe = 1'b1;
        tick();
        checks++; if (bus.rd_data !== 8'h09) begin errors++; $display("FAIL read1_status: got %h expected 09", bus.rd_data); end
        tick();
        checks++; if (bus.rd_data !== 8'h01) begin errors++; $display("FAIL read2_status: got %h expected 01", bus.rd_data); end
        bus_idle();
        fb[0] = 8'h3C; fb[1] = 8'hC3; fb[2] = 8'h5A;
        for (int c = 0; c <= 52; c++) begin
            if (c < 3) begin
                bus_write(8'h01, fb[c]);
            end else if (c == 10) begin
                bus_write(8'h02, 8'h80);
            end else if (c == 11) begin
                bus_idle();
                bus.port_id = 8'h02;
            end else begin
                bus_idle();
            end
            tick();
            checks++;
            if (tx !== exp_line(c, 1)) begin errors++; $display("FAIL flush_tx c=%0d: got %b expected %b", c, tx, exp_line(c, 1)); end
            checks++;
            if (busy !== (c < 41)) begin errors++; $display("FAIL flush_busy c=%0d: got %b expected %b", c, busy, c < 41); end
            if (c == 11) begin
                checks++;
                if (bus.rd_data !== 8'h05) begin errors++; $display("FAIL flush_status: got %h expected 05", bus.rd_data); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        fb[0] = 8'hF7;
        for (int c = 0; c <= 17; c++) begin
            if (c < 6) bus_write(8'h01, 8'(8'hF7 - c)); else bus_idle();
            tick();
            checks++;
            if (tx !== exp_line(c, 1)) begin errors++; $display("FAIL rstmid_tx c=%0d: got %b expected %b", c, tx, exp_line(c, 1)); end
        end
        reset = 1'b1;
        tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx_after: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rstmid_full: got %b expected 0", fifo_full); end
        reset = 1'b0;
        bus.port_id = 8'h02;
        tick();
        checks++; if (bus.rd_data !== 8'h01) begin errors++; $display("FAIL rstmid_status: got %h expected 01", bus.rd_data); end
        bus_idle();
        for (int c = 0; c < 60; c++) begin
            tick();
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL rstmid_quiet c=%0d: got tx=%b busy=%b expected tx=1 busy=0", c, tx, busy);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus_idle();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_status_flush();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
